code_lock_ctrl: RTL and testbench
=================================

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 Parameters: CODE_DEFAULT=12'h123 (3 BCD digits, reset code); TICKS_PER_SEC=50_000_000 (CLK cycles per second); MAX_TRIES=3 (range 1..3); OPEN_SECS=5; FAIL_SECS=2; LOCK_SECS=10 (each second value 1..15).
REQ-002 Ports: CLK in 1 clock; reset in 1 synchronous, active-high reset.
REQ-003 iNum1/iNum2/iNum3 in 4 each: digits from the keypad decoder; iNum1 is the most significant.
REQ-004 iNumRdy in 1: level from the keypad decoder; high = three digits valid; stays high until the decoder is cleared.
REQ-005 iProg in 1: program switch; sampled only in OPEN.
REQ-006 oKbdClr out 1: one-cycle pulse that re-arms the keypad decoder.
REQ-007 oState out 3: IDLE=0, CHECK=1, OPEN=2, FAIL=3, LOCKOUT=4.
REQ-008 oUnlock out 1: high in OPEN.
REQ-009 oAlarm out 1: high in LOCKOUT.
REQ-010 oTriesLeft out 2: remaining attempts.
REQ-011 oSecs out 4: seconds remaining in the timed states; 0 elsewhere.
REQ-012 oLED out 8: {oUnlock, oAlarm, FAIL flag, oSecs, 1'b0}. Bit 7 = oUnlock, bit 6 = oAlarm, bit 5 = FAIL flag, bits 4:1 = oSecs, bit 0 = 0.

Function
REQ-013 IDLE: when iNumRdy=1 and the guard is clear, the block SHALL latch the three digits, assert oKbdClr, and enter CHECK on the next cycle.
REQ-014 Guard: iNumRdy SHALL be ignored in the cycle oKbdClr is high and in the following cycle. This covers the decoder's registered clear latency.
REQ-015 CHECK (exactly 1 cycle): latched digits equal to the code register -> OPEN, with tries reloaded to MAX_TRIES.
REQ-016 CHECK mismatch: tries decrements by 1. New tries=0 -> LOCKOUT. Otherwise -> FAIL.
REQ-017 CHECK: any latched digit greater than 9 SHALL count as a mismatch.
REQ-018 Timed states (OPEN, FAIL, LOCKOUT): on entry the seconds counter loads OPEN_SECS, FAIL_SECS or LOCK_SECS respectively, and the prescaler clears to 0.
REQ-019 Timed-state countdown: oSecs decrements on each prescaler wrap, which occurs every TICKS_PER_SEC cycles.
REQ-020 Timed-state exit: on the wrap at which oSecs=1, the block SHALL go to IDLE on the next cycle, with oSecs=0.
REQ-021 LOCKOUT exit SHALL also reload tries to MAX_TRIES.
REQ-022 OPEN with iNumRdy=1 (guard clear) and iProg=1: the code register takes {iNum1,iNum2,iNum3} only if all three digits are ≤9. The block pulses oKbdClr and goes to IDLE.
REQ-023 OPEN with iNumRdy=1 (guard clear) and iProg=0: the block pulses oKbdClr and stays in OPEN; the timer is unaffected.
REQ-024 FAIL/LOCKOUT with iNumRdy=1 (guard clear): the entry is discarded with an oKbdClr pulse; state, tries and timer are unchanged.
REQ-025 If iNumRdy and a timer expiry fall on the same cycle, expiry wins. The entry stays pending and is handled in IDLE on a later cycle.
REQ-026 Counter widths: prescaler is $clog2(TICKS_PER_SEC) bits, seconds counter 4 bits, tries 2 bits; tries never underflows.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.
REQ-028 Unused state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-029 Reset values: state=IDLE, code register=CODE_DEFAULT, tries=MAX_TRIES, prescaler=0, seconds=0, guard clear.
REQ-030 On reset all outputs SHALL be 0, except oTriesLeft=MAX_TRIES and oState=0.
REQ-031 Reset asserted mid-timer or in CHECK SHALL abort the operation; the next cycle after release behaves as fresh IDLE.

Structure
REQ-032 A shared package SHALL hold the state encoding constants, the parameter defaults, and the BCD digit width (4).
REQ-033 The prescaler plus seconds countdown SHALL be one sub-module, sec_timer, with inputs load, load value and CLK/reset, and outputs secs and expire.
REQ-034 The FSM, code register and tries counter SHALL live in code_lock_ctrl.

Verification (TICKS_PER_SEC=4, OPEN_SECS=2, FAIL_SECS=1, LOCK_SECS=3)
REQ-035 Correct code: reset, then digits 1,2,3 with iNumRdy -> oKbdClr pulses once; one cycle in CHECK; OPEN with oUnlock=1 and oSecs=2; IDLE 8 cycles after OPEN entry.
REQ-036 Wrong code: 4,5,6 -> FAIL with oTriesLeft=2 and oLED[5]=1; IDLE 4 cycles later.
REQ-037 Three wrong codes -> LOCKOUT with oAlarm=1 and oTriesLeft=0. An entry during LOCKOUT gets an oKbdClr pulse and no other effect. IDLE after 12 cycles with oTriesLeft=3.
REQ-038 Programming: OPEN, iProg=1, digits 7,8,9 -> IDLE. Then 1,2,3 -> FAIL; 7,8,9 -> OPEN. Digit value 10 while programming leaves the code unchanged.
REQ-039 Guard and reset: iNumRdy held high for 1 cycle after oKbdClr -> no second latch. Reset asserted in OPEN -> IDLE, code=CODE_DEFAULT, oUnlock=0.

Source files
------------

// File: rtl/code_lock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// code_lock_ctrl_pkg
// Shared definitions for the code lock controller: state encoding, parameter
// defaults, BCD digit width and a BCD validity helper.
// No ports (package).
// -----------------------------------------------------------------------------
package code_lock_ctrl_pkg;

   localparam int DIGIT_W = 4;
   localparam int CODE_W  = 3 * DIGIT_W;

   localparam logic [CODE_W-1:0] CODE_DEFAULT_P = 12'h123;
   localparam int TICKS_PER_SEC_P = 50_000_000;
   localparam int MAX_TRIES_P     = 3;
   localparam int OPEN_SECS_P     = 5;
   localparam int FAIL_SECS_P     = 2;
   localparam int LOCK_SECS_P     = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   // True when every one of the three packed digits is a legal BCD value.
   function automatic logic digits_valid(input logic [CODE_W-1:0] code);
      return (code[11:8] <= 4'd9) && (code[7:4] <= 4'd9) && (code[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/code_lock_ctrl_sec_timer.sv
// -----------------------------------------------------------------------------
// sec_timer
// Prescaler plus 4-bit seconds countdown for the timed lock states.
// Ports:
//   CLK, reset  : clock, synchronous active-high reset
//   load        : load seconds with load_val and clear the prescaler
//   load_val[3:0]: seconds value to load (0 stops the timer)
//   secs[3:0]   : seconds remaining (registered)
//   expire      : high in the cycle whose prescaler wrap takes secs from 1 to 0
// -----------------------------------------------------------------------------
module sec_timer #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] secs,
   output logic       expire
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] WRAP_C = PW'(TICKS_PER_SEC - 1);

   logic [PW-1:0] presc_r;
   logic [3:0]    secs_r;
   logic          wrap_s;

   assign wrap_s = (presc_r == WRAP_C);
   assign expire = wrap_s && (secs_r == 4'd1);
   assign secs   = secs_r;

   // Prescaler and seconds countdown; idle while secs is zero.
   always_ff @(posedge CLK) begin
      if (reset) begin
         presc_r <= '0;
         secs_r  <= 4'd0;
      end else if (load) begin
         presc_r <= '0;
         secs_r  <= load_val;
      end else if (secs_r != 4'd0) begin
         if (wrap_s) begin
            presc_r <= '0;
            secs_r  <= secs_r - 4'd1;
         end else begin
            presc_r <= presc_r + PW'(1);
         end
      end else begin
         presc_r <= '0;
      end
   end

endmodule

// File: rtl/code_lock_ctrl.sv
// -----------------------------------------------------------------------------
// code_lock_ctrl
// Keypad code lock: latches three BCD digits, compares them with a
// programmable code, opens / fails / locks out with timed states.
// Ports:
//   CLK, reset          : clock, synchronous active-high reset
//   iNum1..iNum3 [3:0]  : keypad digits, iNum1 most significant
//   iNumRdy             : digits valid (level, held until decoder cleared)
//   iProg               : program switch, honoured only in OPEN
//   oKbdClr             : one-cycle pulse re-arming the keypad decoder
//   oState [2:0]        : current state encoding
//   oUnlock, oAlarm     : OPEN / LOCKOUT indicators
//   oTriesLeft [1:0]    : remaining attempts
//   oSecs [3:0]         : seconds remaining in timed states
//   oLED [7:0]          : {oUnlock, oAlarm, fail, oSecs, 0}
// -----------------------------------------------------------------------------
module code_lock_ctrl
   import code_lock_ctrl_pkg::*;
#(
   parameter logic [11:0] CODE_DEFAULT  = CODE_DEFAULT_P,
   parameter int          TICKS_PER_SEC = TICKS_PER_SEC_P,
   parameter int          MAX_TRIES     = MAX_TRIES_P,
   parameter int          OPEN_SECS     = OPEN_SECS_P,
   parameter int          FAIL_SECS     = FAIL_SECS_P,
   parameter int          LOCK_SECS     = LOCK_SECS_P
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic [3:0]   iNum1,
   input  logic [3:0]   iNum2,
   input  logic [3:0]   iNum3,
   input  logic         iNumRdy,
   input  logic         iProg,
   output logic         oKbdClr,
   output logic [2:0]   oState,
   output logic         oUnlock,
   output logic         oAlarm,
   output logic [1:0]   oTriesLeft,
   output logic [3:0]   oSecs,
   output logic [7:0]   oLED
);

   localparam logic [1:0] MAX_TRIES_C = 2'(MAX_TRIES);
   localparam logic [3:0] OPEN_SECS_C = 4'(OPEN_SECS);
   localparam logic [3:0] FAIL_SECS_C = 4'(FAIL_SECS);
   localparam logic [3:0] LOCK_SECS_C = 4'(LOCK_SECS);

   state_t            state_r;
   logic [CODE_W-1:0] code_r;
   logic [CODE_W-1:0] dig_r;
   logic [1:0]        tries_r;
   logic              kbd_clr_r;
   logic              kbd_clr_d_r;

   logic              guard_s;
   logic              accept_s;
   logic              match_s;
   logic [CODE_W-1:0] entry_s;
   logic              load_s;
   logic [3:0]        load_val_s;
   logic [3:0]        secs_s;
   logic              expire_s;

   // The decoder clears one cycle after oKbdClr, so iNumRdy is untrusted
   // during the pulse and the cycle after it.
   assign guard_s  = kbd_clr_r | kbd_clr_d_r;
   assign accept_s = iNumRdy & ~guard_s;
   assign entry_s  = {iNum1, iNum2, iNum3};
   assign match_s  = (dig_r == code_r) && digits_valid(dig_r);

   // Timer load decode: entry into a timed state, or a programming exit
   // from OPEN which must zero the remaining seconds.
   always_comb begin
      load_s     = 1'b0;
      load_val_s = 4'd0;
      case (state_r)
         ST_CHECK: begin
            load_s = 1'b1;
            if (match_s) begin
               load_val_s = OPEN_SECS_C;
            end else if (tries_r <= 2'd1) begin
               load_val_s = LOCK_SECS_C;
            end else begin
               load_val_s = FAIL_SECS_C;
            end
         end
         ST_OPEN: begin
            if (!expire_s && accept_s && iProg) begin
               load_s = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         default: begin
            load_s     = 1'b0;
            load_val_s = 4'd0;
         end
      endcase
   end

   sec_timer #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_sec_timer (
      .CLK      (CLK),
      .reset    (reset),
      .load     (load_s),
      .load_val (load_val_s),
      .secs     (secs_s),
      .expire   (expire_s)
   );

   // Lock FSM with code register, tries counter and keypad clear pulse.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         code_r      <= CODE_DEFAULT;
         dig_r       <= '0;
         tries_r     <= MAX_TRIES_C;
         kbd_clr_r   <= 1'b0;
         kbd_clr_d_r <= 1'b0;
      end else begin
         kbd_clr_r   <= 1'b0;
         kbd_clr_d_r <= kbd_clr_r;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  dig_r     <= entry_s;
                  kbd_clr_r <= 1'b1;
                  state_r   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (match_s) begin
                  tries_r <= MAX_TRIES_C;
                  state_r <= ST_OPEN;
               end else if (tries_r <= 2'd1) begin
                  tries_r <= 2'd0;
                  state_r <= ST_LOCKOUT;
               end else begin
                  tries_r <= tries_r - 2'd1;
                  state_r <= ST_FAIL;
               end
            end
            ST_OPEN: begin
               // Expiry takes priority; a pending entry is served from IDLE.
               if (expire_s) begin
                  state_r <= ST_IDLE;
               end else if (accept_s) begin
                  kbd_clr_r <= 1'b1;
                  if (iProg) begin
                     if (digits_valid(entry_s)) begin
                        code_r <= entry_s;
                     end
                     state_r <= ST_IDLE;
                  end
               end
            end
            ST_FAIL: begin
               if (expire_s) begin
                  state_r <= ST_IDLE;
               end else if (accept_s) begin
                  kbd_clr_r <= 1'b1;
               end
            end
            ST_LOCKOUT: begin
               if (expire_s) begin
                  tries_r <= MAX_TRIES_C;
                  state_r <= ST_IDLE;
               end else if (accept_s) begin
                  kbd_clr_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign oKbdClr    = kbd_clr_r;
   assign oState     = state_r;
   assign oUnlock    = (state_r == ST_OPEN);
   assign oAlarm     = (state_r == ST_LOCKOUT);
   assign oTriesLeft = tries_r;
   assign oSecs      = secs_s;
   assign oLED       = {oUnlock, oAlarm, (state_r == ST_FAIL), secs_s, 1'b0};

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with a short seconds prescale.
module tb_code_lock_ctrl;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] iNum1 = 4'd0;
   logic [3:0] iNum2 = 4'd0;
   logic [3:0] iNum3 = 4'd0;
   logic       iNumRdy = 1'b0;
   logic       iProg = 1'b0;
   logic       oKbdClr;
   logic [2:0] oState;
   logic       oUnlock;
   logic       oAlarm;
   logic [1:0] oTriesLeft;
   logic [3:0] oSecs;
   logic [7:0] oLED;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_OPEN = 3'd2;
   localparam logic [2:0] S_FAIL = 3'd3;
   localparam logic [2:0] S_LOCK = 3'd4;

   code_lock_ctrl #(
      .CODE_DEFAULT  (12'h123),
      .TICKS_PER_SEC (4),
      .MAX_TRIES     (3),
      .OPEN_SECS     (2),
      .FAIL_SECS     (1),
      .LOCK_SECS     (3)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .iNum1      (iNum1),
      .iNum2      (iNum2),
      .iNum3      (iNum3),
      .iNumRdy    (iNumRdy),
      .iProg      (iProg),
      .oKbdClr    (oKbdClr),
      .oState     (oState),
      .oUnlock    (oUnlock),
      .oAlarm     (oAlarm),
      .oTriesLeft (oTriesLeft),
      .oSecs      (oSecs),
      .oLED       (oLED)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Present a code, hold iNumRdy through the guard window, then release.
   // Returns one cycle after the timed state is entered.
   task automatic enter(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                        input logic [2:0] exp_st, input logic [1:0] exp_tries);
      iNum1 = d1; iNum2 = d2; iNum3 = d3; iNumRdy = 1'b1;
      step(1);
      chk("latch_clr", oKbdClr, 1);
      chk("check_state", oState, S_CHECK);
      step(1);
      chk("result_state", oState, exp_st);
      chk("result_tries", oTriesLeft, exp_tries);
      chk("clr_single", oKbdClr, 0);
      step(1);
      chk("guard_no_relatch", oKbdClr, 0);
      chk("guard_state", oState, exp_st);
      iNumRdy = 1'b0;
   endtask

   // Wait out a timed state: n cycles from now it must be IDLE, not before.
   task automatic wait_exit(input int n, input logic [2:0] st);
      step(n - 1);
      chk("before_expire", oState, st);
      step(1);
      chk("after_expire", oState, S_IDLE);
      chk("secs_zero", oSecs, 0);
   endtask

   initial begin
      // Reset state
      step(2);
      chk("rst_state", oState, S_IDLE);
      chk("rst_tries", oTriesLeft, 3);
      chk("rst_unlock", oUnlock, 0);
      chk("rst_alarm", oAlarm, 0);
      chk("rst_secs", oSecs, 0);
      chk("rst_led", oLED, 8'h00);
      chk("rst_clr", oKbdClr, 0);
      reset = 1'b0;
      step(1);

      // Correct code opens for 2 s (8 cycles)
      enter(4'd1, 4'd2, 4'd3, S_OPEN, 2'd3);
      chk("open_unlock", oUnlock, 1);
      chk("open_secs", oSecs, 2);
      chk("open_led", oLED, 8'h84);
      step(3);
      chk("open_secs1", oSecs, 1);
      chk("open_led1", oLED, 8'h82);
      wait_exit(4, S_OPEN);
      chk("open_unlock_off", oUnlock, 0);

      // Wrong code -> FAIL for 1 s
      enter(4'd4, 4'd5, 4'd6, S_FAIL, 2'd2);
      chk("fail_led", oLED, 8'h22);
      wait_exit(3, S_FAIL);

      // Two more wrong codes -> LOCKOUT
      enter(4'd4, 4'd5, 4'd6, S_FAIL, 2'd1);
      wait_exit(3, S_FAIL);
      enter(4'd4, 4'd5, 4'd6, S_LOCK, 2'd0);
      chk("lock_alarm", oAlarm, 1);
      chk("lock_led", oLED, 8'h46);
      iNum1 = 4'd1; iNum2 = 4'd2; iNum3 = 4'd3; iNumRdy = 1'b1;
      step(1);
      chk("lock_discard_clr", oKbdClr, 1);
      chk("lock_discard_state", oState, S_LOCK);
      chk("lock_discard_tries", oTriesLeft, 0);
      chk("lock_discard_secs", oSecs, 3);
      iNumRdy = 1'b0;
      step(1);
      chk("lock_clr_off", oKbdClr, 0);
      wait_exit(9, S_LOCK);
      chk("lock_tries_reload", oTriesLeft, 3);
      chk("lock_alarm_off", oAlarm, 0);

      // Program new code 7,8,9
      enter(4'd1, 4'd2, 4'd3, S_OPEN, 2'd3);
      iProg = 1'b1; iNum1 = 4'd7; iNum2 = 4'd8; iNum3 = 4'd9; iNumRdy = 1'b1;
      step(1);
      chk("prog_clr", oKbdClr, 1);
      chk("prog_state", oState, S_IDLE);
      chk("prog_secs", oSecs, 0);
      chk("prog_unlock", oUnlock, 0);
      iNumRdy = 1'b0; iProg = 1'b0;
      step(2);
      enter(4'd1, 4'd2, 4'd3, S_FAIL, 2'd2);
      wait_exit(3, S_FAIL);
      enter(4'd7, 4'd8, 4'd9, S_OPEN, 2'd3);

      // Programming with a non-BCD digit leaves the code unchanged
      iProg = 1'b1; iNum1 = 4'hA; iNum2 = 4'd1; iNum3 = 4'd2; iNumRdy = 1'b1;
      step(1);
      chk("badprog_state", oState, S_IDLE);
      iNumRdy = 1'b0; iProg = 1'b0;
      step(2);
      enter(4'd7, 4'd8, 4'd9, S_OPEN, 2'd3);

      // Entry arriving on the expiry cycle: expiry wins, entry served later
      step(6);
      chk("pre_expiry_state", oState, S_OPEN);
      iNum1 = 4'd7; iNum2 = 4'd8; iNum3 = 4'd9; iNumRdy = 1'b1;
      step(1);
      chk("expiry_wins_state", oState, S_IDLE);
      chk("expiry_wins_clr", oKbdClr, 0);
      step(1);
      chk("pending_clr", oKbdClr, 1);
      chk("pending_check", oState, S_CHECK);
      step(1);
      chk("pending_open", oState, S_OPEN);
      step(1);
      chk("pending_guard", oKbdClr, 0);
      iNumRdy = 1'b0;

      // Reset while OPEN
      reset = 1'b1;
      step(1);
      chk("mid_rst_state", oState, S_IDLE);
      chk("mid_rst_unlock", oUnlock, 0);
      chk("mid_rst_secs", oSecs, 0);
      chk("mid_rst_tries", oTriesLeft, 3);
      reset = 1'b0;
      step(1);
      enter(4'd1, 4'd2, 4'd3, S_OPEN, 2'd3);
      chk("default_code_unlock", oUnlock, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
